ex_mem_wb_backend: RTL and testbench

- Back end of the five-stage MIPS pipeline. Consumes the ID/EX register outputs.
- Contains, in order: EX stage (ALU, ALU control, branch target, destination mux), EX/MEM register, word-addressed data memory, MEM/WB register.
- Returns the branch-redirect signals (PCSrc, BranchPC) and the register-file write-back signals (RegWrite, WriteReg, WriteData) to the ID/IF side.

---
 rtl/ex_mem_wb_backend.sv | 172 +++++++++++++++++
 tb/tb_ex_mem_wb_backend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_backend.sv
// ex_mem_wb_backend
//   Back half of a five-stage MIPS pipeline: the EX stage (ALU, ALU control,
//   branch target, destination mux), the EX/MEM register, a word-addressed
//   data memory, and the MEM/WB register. It returns the branch redirect to
//   IF and the register-file write-back to ID.
//
// Ports
//   Clk, Rst_n     rising-edge clock, synchronous active-low reset
//   PC_IN          PC+4 of the instruction in EX
//   RD1_IN/RD2_IN  rs / rt operands (RD2 is also the store data)
//   IR_LO_EX_IN    sign-extended immediate, [5:0] = funct
//   WR1_IN/WR2_IN  rt / rd register fields
//   WB_IN          {RegWrite, MemtoReg}
//   MEM_IN         {Branch, MemRead, MemWrite}
//   EX_IN          {RegDst, ALUOp[1:0], ALUSrc}
//   PCSrc/BranchPC taken-branch redirect, driven from EX/MEM
//   RegWrite/WriteReg/WriteData  write-back to the register file
module ex_mem_wb_backend #(
    parameter int DMEM_AW = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] PC_IN,
    input  logic [31:0] RD1_IN,
    input  logic [31:0] RD2_IN,
    input  logic [31:0] IR_LO_EX_IN,
    input  logic [4:0]  WR1_IN,
    input  logic [4:0]  WR2_IN,
    input  logic [1:0]  WB_IN,
    input  logic [2:0]  MEM_IN,
    input  logic [3:0]  EX_IN,
    output logic        PCSrc,
    output logic [31:0] BranchPC,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // ---------------- EX stage ----------------
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] alu_b;
    logic [4:0]  dest;
    logic [31:0] target;
    alu_op_e     alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;

    assign reg_dst = EX_IN[3];
    assign alu_op  = EX_IN[2:1];
    assign alu_src = EX_IN[0];

    assign alu_b  = alu_src ? IR_LO_EX_IN : RD2_IN;
    assign dest   = reg_dst ? WR2_IN : WR1_IN;
    assign target = PC_IN + {IR_LO_EX_IN[29:0], 2'b00};

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            2'b01:   alu_ctrl = ALU_SUB;
            2'b10: begin
                case (IR_LO_EX_IN[5:0])
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            ALU_SUB: alu_result = RD1_IN - alu_b;
            ALU_AND: alu_result = RD1_IN & alu_b;
            ALU_OR:  alu_result = RD1_IN | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(RD1_IN) < $signed(alu_b)};
            default: alu_result = RD1_IN + alu_b;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    // ---------------- EX/MEM register ----------------
    logic [31:0] exmem_alu;
    logic        exmem_zero;
    logic [31:0] exmem_target;
    logic [31:0] exmem_rd2;
    logic [4:0]  exmem_dest;
    logic [1:0]  exmem_wb;
    logic [2:0]  exmem_mem;

    // A taken branch in MEM means the instruction now in EX is wrong-path:
    // its control bits are dropped so it has no architectural effect.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            exmem_alu    <= '0;
            exmem_zero   <= 1'b0;
            exmem_target <= '0;
            exmem_rd2    <= '0;
            exmem_dest   <= '0;
            exmem_wb     <= '0;
            exmem_mem    <= '0;
        end else begin
            exmem_alu    <= alu_result;
            exmem_zero   <= zero;
            exmem_target <= target;
            exmem_rd2    <= RD2_IN;
            exmem_dest   <= dest;
            exmem_wb     <= PCSrc ? 2'b00  : WB_IN;
            exmem_mem    <= PCSrc ? 3'b000 : MEM_IN;
        end
    end

    // ---------------- MEM stage ----------------
    assign PCSrc    = exmem_mem[2] & exmem_zero;
    assign BranchPC = exmem_target;

    logic [31:0]        dmem [0:(1 << DMEM_AW) - 1];
    logic [DMEM_AW-1:0] dmem_index;
    logic [31:0]        read_data;

    // Word index; byte offset and address bits above the memory size are dropped.
    assign dmem_index = exmem_alu[DMEM_AW+1:2];
    assign read_data  = dmem[dmem_index];

    // Contents survive reset, but a store pending at a reset edge is killed.
    always_ff @(posedge Clk) begin
        if (Rst_n && exmem_mem[0]) begin
            dmem[dmem_index] <= exmem_rd2;
        end
    end

    // ---------------- MEM/WB register ----------------
    logic [31:0] memwb_rdata;
    logic [31:0] memwb_alu;
    logic [4:0]  memwb_dest;
    logic [1:0]  memwb_wb;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            memwb_rdata <= '0;
            memwb_alu   <= '0;
            memwb_dest  <= '0;
            memwb_wb    <= '0;
        end else begin
            memwb_rdata <= read_data;
            memwb_alu   <= exmem_alu;
            memwb_dest  <= exmem_dest;
            memwb_wb    <= exmem_wb;
        end
    end

    // ---------------- WB stage ----------------
    // $0 is hard-wired, so a write to it is suppressed here.
    assign RegWrite  = memwb_wb[1] & (memwb_dest != 5'd0);
    assign WriteReg  = memwb_dest;
    assign WriteData = memwb_wb[0] ? memwb_rdata : memwb_alu;

endmodule

// File: tb/tb_ex_mem_wb_backend.sv
// tb_ex_mem_wb_backend
//   Directed bench for ex_mem_wb_backend. Each issued instruction pushes its
//   hand-computed write-back expectation into exp_q; two edges later the
//   entry is popped and compared with RegWrite/WriteReg/WriteData.
//   Entry layout: {check_data, reg_write, write_reg[4:0], write_data[31:0]}.
module tb_ex_mem_wb_backend;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] PC_IN;
    logic [31:0] RD1_IN;
    logic [31:0] RD2_IN;
    logic [31:0] IR_LO_EX_IN;
    logic [4:0]  WR1_IN;
    logic [4:0]  WR2_IN;
    logic [1:0]  WB_IN;
    logic [2:0]  MEM_IN;
    logic [3:0]  EX_IN;
    logic        PCSrc;
    logic [31:0] BranchPC;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    int errors = 0;
    int checks = 0;

    logic [38:0] exp_q[$];
    localparam logic [38:0] EXP_ZERO = {1'b1, 1'b0, 5'd0, 32'd0};

    ex_mem_wb_backend #(.DMEM_AW(8)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .PC_IN       (PC_IN),
        .RD1_IN      (RD1_IN),
        .RD2_IN      (RD2_IN),
        .IR_LO_EX_IN (IR_LO_EX_IN),
        .WR1_IN      (WR1_IN),
        .WR2_IN      (WR2_IN),
        .WB_IN       (WB_IN),
        .MEM_IN      (MEM_IN),
        .EX_IN       (EX_IN),
        .PCSrc       (PCSrc),
        .BranchPC    (BranchPC),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pcsrc"},    {31'd0, PCSrc},    32'd0);
        check({tag, "_branchpc"}, BranchPC,          32'd0);
        check({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
        check({tag, "_writereg"}, {27'd0, WriteReg}, 32'd0);
        check({tag, "_writedata"}, WriteData,        32'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] wr1, input logic [4:0] wr2,
                         input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex);
        PC_IN       = pc;
        RD1_IN      = rd1;
        RD2_IN      = rd2;
        IR_LO_EX_IN = imm;
        WR1_IN      = wr1;
        WR2_IN      = wr2;
        WB_IN       = wb;
        MEM_IN      = mem;
        EX_IN       = ex;
    endtask

    // Present one instruction for one cycle, then score whatever reached WB.
    task automatic issue(input string tag,
                         input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] wr1, input logic [4:0] wr2,
                         input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                         input logic full, input logic rw, input logic [4:0] wr, input logic [31:0] wd);
        logic [38:0] e;
        drive(pc, rd1, rd2, imm, wr1, wr2, wb, mem, ex);
        exp_q.push_back({full, rw, wr, wd});
        @(posedge Clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check({tag, "_regwrite"}, {31'd0, RegWrite}, {31'd0, e[37]});
            if (e[38]) begin
                check({tag, "_writereg"}, {27'd0, WriteReg}, {27'd0, e[36:32]});
                check({tag, "_writedata"}, WriteData, e[31:0]);
            end
        end
    endtask

    task automatic rtype(input string tag, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [5:0] funct, input logic [4:0] rd, input logic [31:0] wd);
        issue(tag, 32'd0, rd1, rd2, {26'd0, funct}, 5'd31, rd, 2'b10, 3'b000, 4'b1100,
              1'b1, rd != 5'd0, rd, wd);
    endtask

    task automatic sw(input string tag, input logic [31:0] base, input logic [31:0] imm,
                      input logic [31:0] data);
        issue(tag, 32'd0, base, data, imm, 5'd0, 5'd0, 2'b00, 3'b001, 4'b0001,
              1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic lw(input string tag, input logic [31:0] base, input logic [31:0] imm,
                      input logic [4:0] rt, input logic [31:0] wd);
        issue(tag, 32'd0, base, 32'd0, imm, rt, 5'd0, 2'b11, 3'b010, 4'b0001,
              1'b1, 1'b1, rt, wd);
    endtask

    task automatic beq(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rd1, input logic [31:0] rd2);
        issue(tag, pc, rd1, rd2, imm, 5'd0, 5'd0, 2'b00, 3'b100, 4'b0010,
              1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic nop(input string tag);
        issue(tag, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 3'b000, 4'b0000,
              1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Rst_n = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 3'b000, 4'b0000);
        repeat (2) @(posedge Clk);
        #1;
        check_outputs_zero("reset");
        Rst_n = 1'b1;
        exp_q = '{EXP_ZERO};

        // ALU operations through write-back
        rtype("add",      32'd5,        32'd7,        6'b100000, 5'd3,  32'd12);
        rtype("slt_neg",  32'hFFFFFFFF, 32'd1,        6'b101010, 5'd4,  32'd1);
        rtype("sub",      32'd4,        32'd9,        6'b100010, 5'd5,  32'hFFFFFFFB);
        rtype("and",      32'h0000F0F0, 32'h0000FF00, 6'b100100, 5'd6,  32'h0000F000);
        rtype("or",       32'h0000F0F0, 32'h00000F00, 6'b100101, 5'd7,  32'h0000FFF0);
        rtype("funct_df", 32'd2,        32'd3,        6'b000000, 5'd9,  32'd5);
        rtype("slt_pos",  32'd5,        32'd3,        6'b101010, 5'd13, 32'd0);
        rtype("wr_zero",  32'd3,        32'd4,        6'b100000, 5'd0,  32'd7);
        issue("aluop11", 32'd0, 32'd10, 32'd0, 32'd6, 5'd10, 5'd0, 2'b10, 3'b000, 4'b0111,
              1'b1, 1'b1, 5'd10, 32'd16);

        // store then immediate load of the same word
        sw("sw1", 32'h10, 32'd4, 32'hDEADBEEF);
        lw("lw1", 32'h10, 32'd4, 5'd8, 32'hDEADBEEF);

        // address wrap and ignored byte offset
        sw("sw_wrap", 32'h400, 32'd8, 32'hA5A5A5A5);
        lw("lw_wrap", 32'h0, 32'd8, 5'd14, 32'hA5A5A5A5);
        lw("lw_byte", 32'h0, 32'h0B, 5'd15, 32'hA5A5A5A5);

        // taken beq flushes a following store
        beq("beq1", 32'h100, 32'd3, 32'd9, 32'd9);
        check("beq1_pcsrc",    {31'd0, PCSrc}, 32'd1);
        check("beq1_branchpc", BranchPC,       32'h0000010C);
        sw("sw_flush", 32'h10, 32'd4, 32'h12345678);
        check("sw_flush_pcsrc", {31'd0, PCSrc}, 32'd0);
        lw("lw_after_flush", 32'h10, 32'd4, 5'd11, 32'hDEADBEEF);

        // taken beq flushes a following add
        beq("beq2", 32'h100, 32'd3, 32'd9, 32'd9);
        check("beq2_pcsrc", {31'd0, PCSrc}, 32'd1);
        issue("add_flush", 32'd0, 32'd1, 32'd1, 32'h20, 5'd0, 5'd12, 2'b10, 3'b000, 4'b1100,
              1'b0, 1'b0, 5'd0, 32'd0);
        nop("drain1");
        nop("drain2");

        // backward branch target
        beq("beq_neg", 32'h200, 32'hFFFFFFFE, 32'd0, 32'd0);
        check("beq_neg_pcsrc",    {31'd0, PCSrc}, 32'd1);
        check("beq_neg_branchpc", BranchPC,       32'h000001F8);
        nop("drain3");

        // not taken
        beq("beq_nt", 32'h300, 32'd5, 32'd1, 32'd2);
        check("beq_nt_pcsrc", {31'd0, PCSrc}, 32'd0);
        nop("drain4");

        // reset while a store and an add to $0 are in flight
        sw("sw_pre", 32'h20, 32'd0, 32'h11111111);
        nop("drain5");
        nop("drain6");
        sw("sw_killed", 32'h20, 32'd0, 32'hCAFEF00D);
        drive(32'd0, 32'd3, 32'd4, 32'h20, 5'd0, 5'd0, 2'b10, 3'b000, 4'b1100);
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        check_outputs_zero("midreset");
        Rst_n = 1'b1;
        exp_q = '{EXP_ZERO};
        lw("lw_after_reset", 32'h20, 32'd0, 5'd16, 32'h11111111);
        nop("drain7");
        nop("drain8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
